// File: rtl/wb_copy_sequencer.sv
// Word-copy engine driving the Wishbone master interface: one read then one write per word,
// with progress, completion and bus-error reporting to the DSP control logic.
module wb_copy_sequencer #(
    parameter int unsigned dw = 32,
    parameter int unsigned aw = 32,
    parameter int unsigned CW = 16
) (
    input  logic          wb_clk,
    input  logic          wb_rst_n,
    input  logic          go,
    input  logic [aw-1:0] src_addr,
    input  logic [aw-1:0] dst_addr,
    input  logic [CW-1:0] word_count,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [aw-1:0] err_addr,
    output logic [CW-1:0] words_done,
    output logic          mst_start,
    output logic [aw-1:0] mst_address,
    output logic [3:0]    mst_selection,
    output logic          mst_write,
    output logic [dw-1:0] mst_data_wr,
    input  logic [dw-1:0] mst_data_rd,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic          wb_rty_i
);

    localparam int unsigned STRIDE = dw / 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        FINISH
    } state_t;

    state_t        state_q, state_d;
    logic [aw-1:0] src_q, src_d, dst_q, dst_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [dw-1:0] buf_q, buf_d;

    logic          busy_d, done_d, error_d, start_d, write_d;
    logic [aw-1:0] err_addr_d, address_d;
    logic [CW-1:0] words_done_d;
    logic [3:0]    sel_d;
    logic [dw-1:0] data_wr_d;

    // Next state, job bookkeeping, then outputs derived from the state being entered
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        rem_d        = rem_q;
        buf_d        = buf_q;
        error_d      = error;
        err_addr_d   = err_addr;
        words_done_d = words_done;

        case (state_q)
            IDLE: begin
                if (go) begin
                    if (word_count == '0) begin
                        state_d = FINISH;
                    end else begin
                        src_d        = src_addr;
                        dst_d        = dst_addr;
                        rem_d        = word_count;
                        error_d      = 1'b0;
                        err_addr_d   = '0;
                        words_done_d = '0;
                        state_d      = RD_REQ;
                    end
                end
            end
            RD_REQ: state_d = RD_WAIT;
            RD_WAIT: begin
                if (wb_err_i || wb_rty_i) begin
                    error_d    = 1'b1;
                    err_addr_d = src_q;
                    state_d    = FINISH;
                end else if (wb_ack_i) begin
                    buf_d   = mst_data_rd;
                    state_d = WR_REQ;
                end
            end
            WR_REQ: state_d = WR_WAIT;
            WR_WAIT: begin
                if (wb_err_i || wb_rty_i) begin
                    error_d    = 1'b1;
                    err_addr_d = dst_q;
                    state_d    = FINISH;
                end else if (wb_ack_i) begin
                    words_done_d = words_done + CW'(1);
                    src_d        = src_q + aw'(STRIDE);
                    dst_d        = dst_q + aw'(STRIDE);
                    rem_d        = rem_q - CW'(1);
                    state_d      = (rem_q == CW'(1)) ? FINISH : RD_REQ;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d    = (state_d != IDLE);
        done_d    = (state_d == FINISH);
        start_d   = (state_d == RD_REQ) || (state_d == WR_REQ);
        address_d = mst_address;
        sel_d     = mst_selection;
        write_d   = mst_write;
        data_wr_d = mst_data_wr;

        // Wait states hold the request presented in the preceding REQ cycle
        case (state_d)
            RD_REQ: begin
                address_d = src_d;
                sel_d     = 4'hF;
                write_d   = 1'b0;
            end
            WR_REQ: begin
                address_d = dst_d;
                sel_d     = 4'hF;
                write_d   = 1'b1;
                data_wr_d = buf_d;
            end
            RD_WAIT, WR_WAIT: begin
            end
            default: begin
                address_d = '0;
                sel_d     = '0;
                write_d   = 1'b0;
                data_wr_d = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q       <= IDLE;
            src_q         <= '0;
            dst_q         <= '0;
            rem_q         <= '0;
            buf_q         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            err_addr      <= '0;
            words_done    <= '0;
            mst_start     <= 1'b0;
            mst_address   <= '0;
            mst_selection <= '0;
            mst_write     <= 1'b0;
            mst_data_wr   <= '0;
        end else begin
            state_q       <= state_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            rem_q         <= rem_d;
            buf_q         <= buf_d;
            busy          <= busy_d;
            done          <= done_d;
            error         <= error_d;
            err_addr      <= err_addr_d;
            words_done    <= words_done_d;
            mst_start     <= start_d;
            mst_address   <= address_d;
            mst_selection <= sel_d;
            mst_write     <= write_d;
            mst_data_wr   <= data_wr_d;
        end
    end

endmodule

// File: tb/tb_wb_copy_sequencer.sv
// Bench for wb_copy_sequencer: job table plus hand-written corner sequences, with a slave
// model whose observed bus transactions are checked against a scoreboard queue.
module tb_wb_copy_sequencer;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] cnt;
        int          w;
        int          et;
        bit          rty;
        logic [15:0] exp_words;
        bit          exp_err;
        logic [31:0] exp_eaddr;
        int          exp_lat;
    } vec_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic        wb_clk, wb_rst_n, go;
    logic [31:0] src_addr, dst_addr, err_addr, mst_address, mst_data_wr, mst_data_rd;
    logic [15:0] word_count, words_done;
    logic        busy, done, error, mst_start, mst_write;
    logic [3:0]  mst_selection;
    logic        wb_ack_i, wb_err_i, wb_rty_i;

    int          n_cmp = 0;
    int          n_fail = 0;
    txn_t        sb[$];
    txn_t        mon_e;
    vec_t        vecs[5];

    int          wait_states = 0;
    int          err_txn = -1;
    int          txn_idx = 0;
    int          n_start = 0;
    int          n_done = 0;
    int          cnt = 0;
    bit          rty_mode = 1'b0;
    bit          pend = 1'b0;
    bit          cur_err = 1'b0;
    logic [31:0] rd_base = '0;

    wb_copy_sequencer #(.dw(32), .aw(32), .CW(16)) dut (
        .wb_clk        (wb_clk),
        .wb_rst_n      (wb_rst_n),
        .go            (go),
        .src_addr      (src_addr),
        .dst_addr      (dst_addr),
        .word_count    (word_count),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .err_addr      (err_addr),
        .words_done    (words_done),
        .mst_start     (mst_start),
        .mst_address   (mst_address),
        .mst_selection (mst_selection),
        .mst_write     (mst_write),
        .mst_data_wr   (mst_data_wr),
        .mst_data_rd   (mst_data_rd),
        .wb_ack_i      (wb_ack_i),
        .wb_err_i      (wb_err_i),
        .wb_rty_i      (wb_rty_i)
    );

    initial begin
        wb_clk = 1'b0;
        forever #5 wb_clk = ~wb_clk;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {7'b0, busy, done, error, err_addr, words_done, mst_start, mst_address,
                mst_selection, mst_write, mst_data_wr};
    endfunction

    // Slave model: answers every start after wait_states idle cycles, and checks the bus order
    initial begin
        wb_ack_i    = 1'b0;
        wb_err_i    = 1'b0;
        wb_rty_i    = 1'b0;
        mst_data_rd = '0;
        forever begin
            @(posedge wb_clk);
            #1;
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            wb_rty_i = 1'b0;
            if (done) n_done++;
            if (!wb_rst_n) begin
                pend = 1'b0;
            end else if (pend) begin
                if (cnt == 0) begin
                    pend = 1'b0;
                    if (cur_err) begin
                        if (rty_mode) wb_rty_i = 1'b1;
                        else          wb_err_i = 1'b1;
                    end else begin
                        wb_ack_i = 1'b1;
                    end
                end else begin
                    cnt--;
                end
            end
            if (mst_start) begin
                n_start++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_start: got start at %0h expected none", mst_address);
                end else begin
                    mon_e = sb.pop_front();
                    check("bus_dir", 128'(mst_write), 128'(mon_e.wr));
                    check("bus_addr", 128'(mst_address), 128'(mon_e.addr));
                    check("bus_sel", 128'(mst_selection), 128'(4'hF));
                    if (mon_e.wr) check("bus_wdata", 128'(mst_data_wr), 128'(mon_e.data));
                end
                cur_err     = (txn_idx == err_txn);
                txn_idx++;
                mst_data_rd = 32'hA0 + ((mst_address - rd_base) >> 2);
                cnt         = wait_states;
                pend        = 1'b1;
            end
        end
    end

    task automatic setup_job(input vec_t v);
        int   ntx;
        txn_t t;
        wait_states = v.w;
        err_txn     = v.et;
        rty_mode    = v.rty;
        rd_base     = v.src;
        txn_idx     = 0;
        ntx = (v.et >= 0) ? v.et + 1 : 2 * int'(v.cnt);
        for (int k = 0; k < ntx; k++) begin
            t.wr   = (k % 2 == 1);
            t.addr = t.wr ? v.dst + 32'(4 * (k / 2)) : v.src + 32'(4 * (k / 2));
            t.data = 32'hA0 + 32'(k / 2);
            sb.push_back(t);
        end
    endtask

    task automatic run_job(input vec_t v, input int go_again_at);
        int lat;
        int done0;
        setup_job(v);
        done0 = n_done;
        lat   = 0;
        @(posedge wb_clk);
        #1;
        go         = 1'b1;
        src_addr   = v.src;
        dst_addr   = v.dst;
        word_count = v.cnt;
        for (int c = 1; c <= 400 && lat == 0; c++) begin
            @(posedge wb_clk);
            #1;
            go = (c == go_again_at);
            if (go) begin
                src_addr   = 32'h900;
                dst_addr   = 32'hA00;
                word_count = 16'd5;
            end
            if (done) lat = c;
        end
        check("done_latency", 128'(lat), 128'(v.exp_lat));
        check("words_done", 128'(words_done), 128'(v.exp_words));
        check("error", 128'(error), 128'(v.exp_err));
        check("err_addr", 128'(err_addr), 128'(v.exp_eaddr));
        check("busy_at_done", 128'(busy), 128'(1'b1));
        repeat (3) begin
            @(posedge wb_clk);
            #1;
        end
        check("busy_after", 128'(busy), 128'(1'b0));
        check("done_after", 128'(done), 128'(1'b0));
        check("done_pulses", 128'(n_done - done0), 128'(1));
        check("sb_drained", 128'(sb.size()), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vb;
        int   lat;
        int   busy_cycles;
        int   s0;
        bit   found;

        //       src            dst           cnt    w  et  rty  words  err  eaddr          lat
        vecs[0] = '{32'h0000_0100, 32'h0000_0200, 16'd3, 0, -1, 1'b0, 16'd3, 1'b0, 32'h0,         13};
        vecs[1] = '{32'h0000_0100, 32'h0000_0300, 16'd4, 0,  2, 1'b0, 16'd1, 1'b1, 32'h0000_0104,  7};
        vecs[2] = '{32'hFFFF_FFFC, 32'h0000_0040, 16'd2, 0, -1, 1'b0, 16'd2, 1'b0, 32'h0,          9};
        vecs[3] = '{32'h0000_1000, 32'h0000_2000, 16'd2, 3,  3, 1'b1, 16'd1, 1'b1, 32'h0000_2004, 21};
        vecs[4] = '{32'h0000_0500, 32'h0000_0600, 16'd1, 2, -1, 1'b0, 16'd1, 1'b0, 32'h0,          9};

        wb_rst_n   = 1'b0;
        go         = 1'b0;
        src_addr   = '0;
        dst_addr   = '0;
        word_count = '0;
        #12;
        check("reset_outputs", all_outs(), 128'(0));
        @(negedge wb_clk);
        wb_rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_job(vecs[i], -1);

        // go while waiting on the first read must be ignored
        vb = '{32'h0000_0100, 32'h0000_0700, 16'd2, 2, -1, 1'b0, 16'd2, 1'b0, 32'h0, 17};
        run_job(vb, 2);

        // Reset in WR_WAIT with a slow slave
        vb = '{32'h0000_0100, 32'h0000_0200, 16'd2, 5, -1, 1'b0, 16'd0, 1'b0, 32'h0, 0};
        setup_job(vb);
        @(posedge wb_clk);
        #1;
        go         = 1'b1;
        src_addr   = vb.src;
        dst_addr   = vb.dst;
        word_count = vb.cnt;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(posedge wb_clk);
            #1;
            go = 1'b0;
            if (busy && mst_write && !mst_start) found = 1'b1;
        end
        check("wr_wait_reached", 128'(found), 128'(1'b1));
        @(posedge wb_clk);
        #3;
        wb_rst_n = 1'b0;
        #1;
        check("async_reset_outputs", all_outs(), 128'(0));
        sb.delete();
        repeat (2) @(negedge wb_clk);
        wb_rst_n = 1'b1;
        s0 = n_start;
        repeat (4) begin
            @(posedge wb_clk);
            #1;
        end
        check("busy_after_reset", 128'(busy), 128'(1'b0));
        check("no_start_after_reset", 128'(n_start - s0), 128'(0));

        // Zero-length job: immediate done, no bus traffic
        s0          = n_start;
        lat         = 0;
        busy_cycles = 0;
        @(posedge wb_clk);
        #1;
        go         = 1'b1;
        src_addr   = 32'h0000_0100;
        dst_addr   = 32'h0000_0200;
        word_count = 16'd0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge wb_clk);
            #1;
            go = 1'b0;
            if (busy) busy_cycles++;
            if (done && lat == 0) lat = c;
        end
        check("zero_done_latency", 128'(lat), 128'(1));
        check("zero_busy_cycles", 128'(busy_cycles), 128'(1));
        check("zero_no_start", 128'(n_start - s0), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
